// File: rtl/small_hb_int.sv
// small_hb_int: halfband x2 interpolator [A 0 B 0.5 B 0 A], one time-shared multiplier.
// Latency: even output registered at E0+2, odd at E0+5; bypass registers the input once.
// No backpressure: inputs closer than 4 clocks are dropped (sticky overrun); SMALL_HB_INT_SAT_EN saturates the odd result.
module small_hb_int #(
  parameter int                 WIDTH   = 18,
  parameter logic signed [17:0] COEFF_A = -18'sd4096,
  parameter logic signed [17:0] COEFF_B = 18'sd36864
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bypass,
  input  logic             stb_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             stb_out,
  output logic [WIDTH-1:0] data_out,
  output logic             overrun
);

  localparam int SW = WIDTH + 1;
  localparam int PW = WIDTH + 19;
  localparam int AW = WIDTH + 20;
  localparam int RW = AW - 16;

  logic signed [WIDTH-1:0] d0, d1, d2, d3;
  logic signed [WIDTH-1:0] even_q, odd_q;
  logic signed [SW-1:0]    sum_a, sum_b;
  logic signed [AW-1:0]    acc, prod_ext, rnd;
  logic signed [17:0]      mul_c;
  logic signed [SW-1:0]    mul_x;
  logic signed [PW-1:0]    prod;
  logic signed [RW-1:0]    shr;
  logic [WIDTH-1:0]        odd_res;
  logic [4:0]              vld;
  logic [2:0]              gap;
  logic                    bypass_q, accept, bypass_chg;
  logic                    unused_bits;

  always_comb begin
    accept     = stb_in && (gap == 3'd4);
    bypass_chg = bypass ^ bypass_q;
    // vld[1] issues the outer-tap product, vld[2] the inner-tap product
    mul_c    = vld[2] ? COEFF_B : COEFF_A;
    mul_x    = vld[2] ? sum_b : sum_a;
    prod     = {{(PW-18){mul_c[17]}}, mul_c} * {{(PW-SW){mul_x[SW-1]}}, mul_x};
    prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    rnd      = acc + {{(AW-16){1'b0}}, 16'h8000};
    shr      = rnd[AW-1:16];
    odd_res  = shr[WIDTH-1:0];
`ifdef SMALL_HB_INT_SAT_EN
    unused_bits = ^rnd[15:0];
    if (shr[RW-1:WIDTH-1] != {(RW-WIDTH+1){1'b0}} &&
        shr[RW-1:WIDTH-1] != {(RW-WIDTH+1){1'b1}}) begin
      odd_res = shr[RW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`else
    unused_bits = ^{rnd[15:0], shr[RW-1:WIDTH]};
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d0       <= '0;
      d1       <= '0;
      d2       <= '0;
      d3       <= '0;
      sum_a    <= '0;
      sum_b    <= '0;
      even_q   <= '0;
      odd_q    <= '0;
      acc      <= '0;
      vld      <= '0;
      gap      <= 3'd4;
      bypass_q <= 1'b0;
      stb_out  <= 1'b0;
      data_out <= '0;
      overrun  <= 1'b0;
    end else begin
      bypass_q <= bypass;
      if (accept) begin
        d0  <= data_in;
        d1  <= d0;
        d2  <= d1;
        d3  <= d2;
        gap <= 3'd1;
      end else if (gap != 3'd4) begin
        gap <= gap + 3'd1;
      end
      if (stb_in && !accept) overrun <= 1'b1;

      // a bypass toggle abandons everything still in the pipe
      vld <= bypass_chg ? 5'b0 : {vld[3:0], accept && !bypass};
      if (vld[0]) begin
        sum_a  <= {d0[WIDTH-1], d0} + {d3[WIDTH-1], d3};
        sum_b  <= {d1[WIDTH-1], d1} + {d2[WIDTH-1], d2};
        even_q <= d2;
      end
      if (vld[1]) acc <= prod_ext;
      if (vld[2]) acc <= acc + prod_ext;
      if (vld[3]) odd_q <= odd_res;

      stb_out <= 1'b0;
      if (bypass) begin
        if (accept) begin
          stb_out  <= 1'b1;
          data_out <= data_in;
        end
      end else if (!bypass_chg) begin
        if (vld[1]) begin
          stb_out  <= 1'b1;
          data_out <= even_q;
        end else if (vld[4]) begin
          stb_out  <= 1'b1;
          data_out <= odd_q;
        end
      end
    end
  end

endmodule

// File: doc/small_hb_int.md
# small_hb_int

Short halfband interpolator by 2, the transmit-side counterpart of the short halfband decimator. It uses the same impulse-response family [A 0 B 0.5 B 0 A] with a gain of 2, so the DC gain of the output stream is 1. For every accepted input sample it emits two output samples:
- an even sample, which is a delayed copy of an input sample;
- an odd sample, which is the halfband-interpolated midpoint.

It sits ahead of a further interpolation stage in the TX chain and time-shares one multiplier.

## Interface
- WIDTH, 18: sample width, signed two's complement.
- COEFF_A, -4096: outer tap, signed 18-bit, Q1.17 (-0.03125).
- COEFF_B, 36864: inner tap, signed 18-bit, Q1.17 (0.28125). COEFF_A+COEFF_B must equal 32768 for unity DC gain.
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- bypass  in  1  1 = pass input straight through, no interpolation.
- stb_in  in  1  input sample valid, single-cycle pulse.
- data_in  in  WIDTH  input sample, sampled when stb_in=1.
- stb_out  out  1  output sample valid, single-cycle pulse.
- data_out  out  WIDTH  output sample; holds value between strobes.
- overrun  out  1  sticky: a stb_in arrived too soon and was dropped.

## Operation
- The delay line d0..d3 holds the 4 most recent accepted inputs, with d0 newest. It shifts on each accepted stb_in.
- Accept rule: a stb_in is accepted only if at least 4 clocks have elapsed since the last accepted stb_in. The first stb_in after reset is always accepted.
- A stb_in that violates the accept rule:
  - is ignored: no shift and no outputs;
  - sets overrun=1, which stays set until reset.
- Per accepted input, after the shift:
  - even output = d2;
  - odd output = 2·(COEFF_A·(d0+d3) + COEFF_B·(d1+d2)).
- Arithmetic:
  - both pre-add sums are WIDTH+1 bits;
  - products are WIDTH+19 bits;
  - the accumulator is WIDTH+20 bits and keeps full precision;
  - the result is the accumulator >>16, rounded to nearest by adding 2^15 before truncation.
- The result is reduced to WIDTH bits by wrap, or by saturation (see Configuration).
- A single multiplier is shared between the two products: COEFF_A·sum_a first, then COEFF_B·sum_b.
- Bypass:
  - data_out <= data_in and stb_out <= stb_in, each registered once (1-cycle latency);
  - exactly one output per input;
  - the delay line still shifts on accepted inputs;
  - the accept rule and overrun still apply.
- Changing bypass mid-stream: the pipeline is flushed. Any in-flight even/odd outputs are discarded, with no strobe.

## Timing
- Let E0 be the rising edge at which an accepted stb_in=1 is sampled.
- The even output is registered at E0+2. stb_out is high for the one cycle following E0+2.
- The odd output is registered at E0+5. stb_out is high for the one cycle following E0+5.
- With minimum spacing (next input at E0+4), outputs land at E0+2, E0+5, E0+6, E0+9, … and never collide.
- Sustained throughput is 2 outputs per 4 clocks.
- Reset (rst_n=0 at an edge), including mid-operation:
  - stb_out=0, data_out=0, overrun=0;
  - delay line cleared to 0;
  - accept-spacing counter cleared, so the next stb_in is accepted;
  - all in-flight work is abandoned with no strobes.
- The first outputs after reset use the zeroed history.
- A stb_in on the same edge that rst_n=0 is sampled is ignored.

## Configuration
- SMALL_HB_INT_SAT_EN defined: the odd result saturates to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- SMALL_HB_INT_SAT_EN undefined: the odd result wraps, i.e. the low WIDTH bits are kept.
- Even outputs and bypass outputs are exact copies of input samples in both builds, so they are unaffected.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles, then release → stb_out=0, data_out=0, overrun=0. The first stb_in afterwards is accepted.
- **Impulse:** 1024 followed by zeros, spaced 4 clocks, default coefficients → (even, odd) pairs (0,-64), (0,576), (1024,576), (0,-64), (0,0). stb_out fires at E0+2 and E0+5 for each input.
- **DC:** 20 inputs of constant 5000 every 5 clocks → from the 4th input onward every output equals 5000.
- **Overrun:** stb_in at t and at t+2 → the second is dropped and overrun=1 from t+3 until reset. The output sequence matches the run without the second strobe.
- **Saturation:** inputs -131072, 131071, 131071, -131072 (WIDTH=18) → odd output after the 4th input:
  - 131071 with SMALL_HB_INT_SAT_EN;
  - -98305 without.
- **Bypass and mid-op reset:**
  - bypass=1, inputs 7 then -7 → one strobe each, 1 clock later, data_out 7 then -7.
  - Reset asserted at E0+3 of an interpolated input → no odd strobe is emitted.
